// File: rtl/apb_regfile_slave.sv
// APB completer with a bank of byte-writable registers.
// Fixed wait states, PSLVERR on bad alignment, range or privilege.
module apb_regfile_slave #(
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 32,
   parameter int PROT_SIZE = 3,
   parameter int STRB_SIZE = DATA_SIZE / 8,
   parameter int NUM_REGS = 16,
   parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 PSELX,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [ADDR_SIZE-1:0] PADDR,
   input  logic [DATA_SIZE-1:0] PWDATA,
   input  logic [PROT_SIZE-1:0] PPROT,
   input  logic [STRB_SIZE-1:0] PSTRB,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic [DATA_SIZE-1:0] PRDATA
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int SB_W = $clog2(STRB_SIZE);
   localparam logic [ADDR_SIZE-1:0] SPAN =
      ADDR_SIZE'(NUM_REGS * STRB_SIZE);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [3:0]           cnt;
   logic [3:0]           cnt_n;
   logic                 load;
   logic                 commit;
   logic                 wr_q;
   logic                 priv_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [DATA_SIZE-1:0] wdata_q;
   logic [STRB_SIZE-1:0] strb_q;
   logic [DATA_SIZE-1:0] regs [NUM_REGS];
   logic [ADDR_SIZE-1:0] offset;
   logic [IDX_W-1:0]     idx;
   logic                 err;
   logic                 done;
   logic                 unused_prot;

   assign unused_prot = &{1'b0, PPROT[PROT_SIZE-1:1]};

   // Modular subtract: addresses below the base wrap to huge offsets.
   assign offset = addr_q - BASE_ADDR;
   assign idx    = offset[SB_W +: IDX_W];
   assign err    = (offset[1:0] != 2'b00)
                 | (offset >= SPAN)
                 | (idx[IDX_W-1] & ~priv_q);
   assign done   = (state == ACCESS) && (cnt == 4'd0);

   assign PREADY  = done;
   assign PSLVERR = done & err;
   assign PRDATA  = (done && !wr_q && !err) ? regs[idx] : '0;

   // Next-state: sample setup, count wait states, complete or abort.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (PSELX && !PENABLE) begin
               state_n = ACCESS;
               cnt_n   = 4'(WAIT_CYCLES);
               load    = 1'b1;
            end
         end
         ACCESS: begin
            if (!PSELX) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               state_n = IDLE;
               commit  = wr_q & ~err;
            end
         end
      endcase
   end

   // State, wait counter and the request latched at setup.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         wr_q    <= 1'b0;
         priv_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load) begin
            wr_q    <= PWRITE;
            priv_q  <= PPROT[0];
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
         end
      end
   end

   // Register bank: byte-strobed write at the completing edge.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (commit) begin
         for (int b = 0; b < STRB_SIZE; b++) begin
            if (strb_q[b]) regs[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave.
// dut0 runs with two wait states, dut1 with zero.
module tb_apb_regfile_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel [2];
   logic        pen = 1'b0;
   logic        pwr = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [2:0]  pprot = '0;
   logic [3:0]  pstrb = '0;
   logic        pready [2];
   logic        pslverr [2];
   logic [31:0] prdata [2];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          d;
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   apb_regfile_slave #(.WAIT_CYCLES(2)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSELX(psel[0]),
      .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
      .PWDATA(pwdata), .PPROT(pprot), .PSTRB(pstrb),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]),
      .PRDATA(prdata[0])
   );

   apb_regfile_slave #(.WAIT_CYCLES(0)) dut1 (
      .PCLK(clk), .PRESETn(rst_n), .PSELX(psel[1]),
      .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
      .PWDATA(pwdata), .PPROT(pprot), .PSTRB(pstrb),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]),
      .PRDATA(prdata[1])
   );

   // Monitor: every PREADY pops one expected response.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (pready[d]) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pready dut%0d", d);
            end else begin
               mon_e = q.pop_front();
               if (mon_e.d != d) begin
                  errors++;
                  $display("FAIL %s dut: got %0d want %0d",
                           mon_e.name, d, mon_e.d);
               end
               checks++;
               if (pslverr[d] !== mon_e.err) begin
                  errors++;
                  $display("FAIL %s pslverr: got %b want %b",
                           mon_e.name, pslverr[d], mon_e.err);
               end
               checks++;
               if (prdata[d] !== mon_e.rdata) begin
                  errors++;
                  $display("FAIL %s prdata: got %h want %h",
                           mon_e.name, prdata[d], mon_e.rdata);
               end
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic setup(int d, logic wr, logic [31:0] a,
                        logic [31:0] wd, logic [3:0] sb,
                        logic [2:0] pr);
      @(posedge clk);
      #1;
      psel[d] = 1'b1;
      pen     = 1'b0;
      pwr     = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = sb;
      pprot   = pr;
      @(posedge clk);
      #1;
      pen = 1'b1;
   endtask

   task automatic xfer(string name, int d, logic wr,
                       logic [31:0] a, logic [31:0] wd,
                       logic [3:0] sb, logic [2:0] pr,
                       logic [31:0] er, logic ee, int waits);
      exp_t e;
      int   n;
      e.d = d;
      e.rdata = er;
      e.err = ee;
      e.name = name;
      q.push_back(e);
      setup(d, wr, a, wd, sb, pr);
      n = 1;
      @(negedge clk);
      while (!pready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!pready[d]) begin
         errors++;
         $display("FAIL %s timeout: got no pready want pready", name);
      end else if (n != waits + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d",
                  name, n, waits + 1);
      end
   endtask

   task automatic idle(int d);
      @(posedge clk);
      #1;
      psel[d] = 1'b0;
      pen     = 1'b0;
   endtask

   initial begin
      psel[0] = 1'b0;
      psel[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pready", 32'(pready[0]), 32'd0);
      chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
      chk("rst_prdata", prdata[0], 32'd0);
      rst_n = 1'b1;

      xfer("rd_0c_reset", 0, 0, 32'h0C, 0, 4'h0, 3'd1, 32'h0, 0, 2);
      xfer("wr_08_full", 0, 1, 32'h08, 32'h11223344, 4'hF, 3'd1,
           32'h0, 0, 2);
      xfer("wr_08_strb", 0, 1, 32'h08, 32'hDEADBEEF, 4'b0101, 3'd1,
           32'h0, 0, 2);
      xfer("rd_08_merge", 0, 0, 32'h08, 0, 4'h0, 3'd1,
           32'h11AD33EF, 0, 2);
      xfer("rd_06_misal", 0, 0, 32'h06, 0, 4'h0, 3'd1, 32'h0, 1, 2);
      xfer("rd_40_range", 0, 0, 32'h40, 0, 4'h0, 3'd1, 32'h0, 1, 2);
      xfer("wr_3c_misal", 0, 1, 32'h3E, 32'hFFFFFFFF, 4'hF, 3'd1,
           32'h0, 1, 2);
      xfer("rd_08_keep", 0, 0, 32'h08, 0, 4'h0, 3'd1,
           32'h11AD33EF, 0, 2);
      xfer("wr_20_user", 0, 1, 32'h20, 32'h12345678, 4'hF, 3'd0,
           32'h0, 1, 2);
      xfer("rd_20_nowr", 0, 0, 32'h20, 0, 4'h0, 3'd1, 32'h0, 0, 2);
      xfer("wr_20_priv", 0, 1, 32'h20, 32'h12345678, 4'hF, 3'd1,
           32'h0, 0, 2);
      xfer("rd_20_priv", 0, 0, 32'h20, 0, 4'h0, 3'd1,
           32'h12345678, 0, 2);
      xfer("rd_20_user", 0, 0, 32'h20, 0, 4'h0, 3'd0, 32'h0, 1, 2);
      xfer("rd_1c_user", 0, 0, 32'h1C, 0, 4'h0, 3'd0, 32'h0, 0, 2);
      xfer("wr_08_nostrb", 0, 1, 32'h08, 32'h0, 4'h0, 3'd1,
           32'h0, 0, 2);
      xfer("rd_08_nostrb", 0, 0, 32'h08, 0, 4'h0, 3'd1,
           32'h11AD33EF, 0, 2);
      idle(0);

      setup(0, 1, 32'h0C, 32'hFFFFFFFF, 4'hF, 3'd1);
      @(posedge clk);
      #1;
      psel[0] = 1'b0;
      pen = 1'b0;
      repeat (2) @(posedge clk);
      xfer("rd_0c_abort", 0, 0, 32'h0C, 0, 4'h0, 3'd1, 32'h0, 0, 2);
      idle(0);

      xfer("b2b_wr_04", 1, 1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'd1,
           32'h0, 0, 0);
      xfer("b2b_rd_04", 1, 0, 32'h04, 0, 4'h0, 3'd1,
           32'hA5A5A5A5, 0, 0);
      idle(1);

      setup(0, 1, 32'h10, 32'hCAFEF00D, 4'hF, 3'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_pready", 32'(pready[0]), 32'd0);
      chk("midrst_pslverr", 32'(pslverr[0]), 32'd0);
      psel[0] = 1'b0;
      pen = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      xfer("rd_10_midrst", 0, 0, 32'h10, 0, 4'h0, 3'd1, 32'h0, 0, 2);
      xfer("rd_08_cleared", 0, 0, 32'h08, 0, 4'h0, 3'd1, 32'h0, 0, 2);
      idle(0);
      repeat (3) @(posedge clk);

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer (slave) that sits directly downstream of the APB bridge and terminates its PSELX/PENABLE transfers. It holds a bank of byte-writable 32-bit registers, inserts a parameterised number of wait states via PREADY, and returns PSLVERR for misaligned, out-of-range or privilege-violating accesses. PRDATA and PSLVERR feed straight back through the bridge to the CPU.

## Interface
- ADDR_SIZE, 32, address bus width
- DATA_SIZE, 32, data bus width
- PROT_SIZE, 3, protection attribute width
- STRB_SIZE, DATA_SIZE/8, byte strobe width
- NUM_REGS, 16, number of registers (power of two, ≥2)
- BASE_ADDR, 0, byte address of register 0 (NUM_REGS*STRB_SIZE aligned)
- WAIT_CYCLES, 2, wait states inserted per transfer (0..15)

- PCLK  in  1  APB clock, all state on rising edge
- PRESETn  in  1  reset; asynchronous, active-low
- PSELX  in  1  slave select
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_SIZE  byte address
- PWDATA  in  DATA_SIZE  write data
- PPROT  in  PROT_SIZE  protection; bit 0 = privileged
- PSTRB  in  STRB_SIZE  write byte strobes
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  transfer error, valid only with PREADY
- PRDATA  out  DATA_SIZE  read data, valid only with PREADY and PWRITE=0

## Operation
- FSM states IDLE, ACCESS.
- IDLE: on a rising edge with PSELX=1, PENABLE=0 (setup cycle), latch PWRITE, PADDR, PWDATA, PSTRB, PPROT[0]; load wait counter with WAIT_CYCLES; go to ACCESS.
- ACCESS, counter ≠ 0: decrement each edge; PREADY=0.
- ACCESS, counter = 0: PREADY=1; at that edge commit the write (if no error) and return to IDLE.
- ACCESS, PSELX=0 sampled (master abort): return to IDLE, no write, no error.
- Offset = latched PADDR − BASE_ADDR; index = offset / STRB_SIZE.
- Error (PSLVERR=1) if any of: offset[1:0] ≠ 0; offset ≥ NUM_REGS*STRB_SIZE (including PADDR < BASE_ADDR, modular subtract); index ≥ NUM_REGS/2 (upper half) with PPROT[0]=0.
- Write, no error: for each byte i with PSTRB[i]=1, reg[index] byte i ← PWDATA byte i; PSTRB=0 is a legal no-op (OKAY).
- Errored writes leave all registers unchanged; errored reads return PRDATA=0.
- Read, no error: PRDATA = reg[index] at the completing cycle; PRDATA=0 whenever PREADY=0 or PWRITE=1.
- PSLVERR=0 whenever PREADY=0.

## Timing
- Reset (asynchronous assertion): state IDLE, counter 0, all registers 0, PREADY=0, PSLVERR=0, PRDATA=0. Release is sampled synchronously on the next PCLK edge.
- Reset asserted mid-transfer: the transfer is dropped and no partial write is committed.
- All outputs decode from registered state only. There is no combinational path from APB inputs to PREADY, PSLVERR or PRDATA.
- Transfer length = setup cycle + (WAIT_CYCLES+1) access cycles. WAIT_CYCLES=0 gives zero-wait: PREADY is high on the first PENABLE cycle.
- Back-to-back: a setup cycle immediately following the PREADY cycle is accepted with no bubble. Next state after completion is IDLE, which samples that setup cycle.
- Read-after-write to the same register returns the new value. The write commits at the PREADY edge of the earlier transfer.
- Inputs are ignored outside the setup-cycle sample, apart from the PSELX abort check.

## Test plan
- Reset then read index 3 (PADDR=0x0C, PPROT=1) with WAIT_CYCLES=2 → PREADY on 3rd PENABLE cycle, PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x08 with PSTRB=4'b0101, after prior full write 0x11223344 → read 0x08 returns 0x11AD33EF.
- Read 0x06 (misaligned) and 0x40 (out of range, NUM_REGS=16) → PSLVERR=1 with PREADY, PRDATA=0, registers unchanged.
- Write 0x12345678 to 0x20 (index 8) with PPROT=0 → PSLVERR=1, no write. Same write with PPROT=1 → OKAY, readback 0x12345678.
- WAIT_CYCLES=0, back-to-back write 0xA5A5A5A5 to 0x04 then read 0x04 → each transfer is 2 cycles, read returns 0xA5A5A5A5.
- PRESETn asserted during a write's wait state, then read the same address → PREADY/PSLVERR low immediately, register reads 0.
